stream_frame_ctrl: RTL and testbench

//  Frame sequencer in front of top_core. Gates the 8-bit pixel stream into the gauss stage,

---
 rtl/stream_frame_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_stream_frame_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_frame_ctrl.sv
// stream_frame_ctrl: frame sequencer in front of the gauss core.
// Passes the pixel stream through with zero latency while in RUN, counts pixels/lines,
// generates line-end last and start-of-frame, and applies shadowed gauss coefficients and
// thresholds only at frame boundaries (LOAD).
// Optional feature macro: LAST_CHECK_EN (compare upstream s_last against internal line end).
module stream_frame_ctrl #(
  parameter int unsigned DW      = 8,
  parameter int unsigned LINE_W  = 1024,
  parameter int unsigned FRAME_H = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_cont,
  input  logic          i_abort,
  input  logic          i_cfg_wr,
  input  logic [7:0]    i_cfg_coe_00,
  input  logic [7:0]    i_cfg_coe_01,
  input  logic [7:0]    i_cfg_coe_02,
  input  logic [7:0]    i_cfg_coe_11,
  input  logic [7:0]    i_cfg_coe_12,
  input  logic [7:0]    i_cfg_coe_22,
  input  logic [7:0]    i_cfg_gth,
  input  logic [7:0]    i_cfg_gtl,
  input  logic [DW-1:0] i_s_data,
  input  logic          i_s_valid,
  input  logic          i_s_last,
  output logic          o_s_ready,
  output logic [DW-1:0] o_m_data,
  output logic          o_m_valid,
  output logic          o_m_last,
  output logic          o_m_sof,
  input  logic          i_m_ready,
  output logic [7:0]    o_coe_00,
  output logic [7:0]    o_coe_01,
  output logic [7:0]    o_coe_02,
  output logic [7:0]    o_coe_11,
  output logic [7:0]    o_coe_12,
  output logic [7:0]    o_coe_22,
  output logic [7:0]    o_gth,
  output logic [7:0]    o_gtl,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_frame_abort,
  output logic          o_line_err
);

  localparam int unsigned PW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int unsigned LW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StEnd} state_e;

  state_e           r_state;
  logic [PW-1:0]    r_pix_cnt;
  logic [LW-1:0]    r_line_cnt;
  logic             r_frame_abort;
  logic [5:0][7:0]  r_pend_coe;
  logic [7:0]       r_pend_gth;
  logic [7:0]       r_pend_gtl;
  logic [5:0][7:0]  r_act_coe;
  logic [7:0]       r_act_gth;
  logic [7:0]       r_act_gtl;

  logic             w_run;
  logic             w_xfer;
  logic             w_pix_end;
  logic             w_line_end;
  logic             w_abort;
  logic [7:0]       w_load_gtl;
  logic [5:0][7:0]  w_cfg_coe;

  assign w_run      = (r_state == StRun);
  assign w_xfer     = i_s_valid & o_s_ready;
  assign w_pix_end  = (r_pix_cnt == PW'(LINE_W - 1));
  assign w_line_end = (r_line_cnt == LW'(FRAME_H - 1));
  assign w_abort    = i_abort & (r_state != StIdle);
  // Low threshold is clamped so it never exceeds the high threshold once active.
  assign w_load_gtl = (r_pend_gtl > r_pend_gth) ? r_pend_gth : r_pend_gtl;
  assign w_cfg_coe  = {i_cfg_coe_22, i_cfg_coe_12, i_cfg_coe_11,
                       i_cfg_coe_02, i_cfg_coe_01, i_cfg_coe_00};

  // Pending (shadow) configuration, writable in any state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend_coe <= {6{8'h04}};
      r_pend_gth <= 8'd5;
      r_pend_gtl <= 8'd1;
    end else if (i_cfg_wr) begin
      r_pend_coe <= w_cfg_coe;
      r_pend_gth <= i_cfg_gth;
      r_pend_gtl <= i_cfg_gtl;
    end
  end

  // Frame FSM, pixel/line counters, abort pulse and active configuration load.
  // Active config is captured on the edge entering LOAD, from pending as it stood before it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_frame_abort <= 1'b0;
      r_act_coe     <= {6{8'h04}};
      r_act_gth     <= 8'd5;
      r_act_gtl     <= 8'd1;
    end else begin
      r_frame_abort <= 1'b0;
      if (w_abort) begin
        r_state       <= StIdle;
        r_pix_cnt     <= '0;
        r_line_cnt    <= '0;
        r_frame_abort <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start) begin
              r_state   <= StLoad;
              r_act_coe <= r_pend_coe;
              r_act_gth <= r_pend_gth;
              r_act_gtl <= w_load_gtl;
            end
          end
          StLoad: begin
            r_state    <= StRun;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
          end
          StRun: begin
            if (w_xfer) begin
              if (w_pix_end) begin
                r_pix_cnt <= '0;
                if (w_line_end) begin
                  r_line_cnt <= '0;
                  r_state    <= StEnd;
                end else begin
                  r_line_cnt <= r_line_cnt + 1'b1;
                end
              end else begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
              end
            end
          end
          StEnd: begin
            if (i_cont) begin
              r_state   <= StLoad;
              r_act_coe <= r_pend_coe;
              r_act_gth <= r_pend_gth;
              r_act_gtl <= w_load_gtl;
            end else begin
              r_state <= StIdle;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

`ifdef LAST_CHECK_EN
  logic r_line_err;

  // Sticky upstream-last mismatch flag; a new frame start clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_line_err <= 1'b0;
    end else if ((r_state == StIdle) && i_start) begin
      r_line_err <= 1'b0;
    end else if (w_xfer && (i_s_last != o_m_last)) begin
      r_line_err <= 1'b1;
    end
  end

  assign o_line_err = r_line_err;
`else
  logic w_unused_s_last;
  assign w_unused_s_last = i_s_last;
  assign o_line_err      = 1'b0;
`endif

  // Zero-latency pass-through and status outputs.
  always_comb begin
    o_m_data     = i_s_data;
    o_m_valid    = i_s_valid & w_run;
    o_s_ready    = i_m_ready & w_run;
    o_m_last     = w_run & w_pix_end;
    o_m_sof      = w_run & (r_pix_cnt == '0) & (r_line_cnt == '0);
    o_busy       = (r_state != StIdle);
    // Abort in END suppresses the done pulse.
    o_frame_done = (r_state == StEnd) & ~i_abort;
  end

  assign o_frame_abort = r_frame_abort;
  assign o_coe_00      = r_act_coe[0];
  assign o_coe_01      = r_act_coe[1];
  assign o_coe_02      = r_act_coe[2];
  assign o_coe_11      = r_act_coe[3];
  assign o_coe_12      = r_act_coe[4];
  assign o_coe_22      = r_act_coe[5];
  assign o_gth         = r_act_gth;
  assign o_gtl         = r_act_gtl;

endmodule

// File: tb/tb_stream_frame_ctrl.sv
// Self-checking bench for stream_frame_ctrl with a reduced frame (8 x 4 pixels).
// A transaction-level model (pixel index within frame, config arrays) is compared every cycle.
module tb_stream_frame_ctrl;
  localparam int DW   = 8;
  localparam int LW   = 8;
  localparam int FH   = 4;
  localparam int NPIX = LW * FH;

  logic clk, rst, start, cont, abort, cfg_wr;
  logic [7:0] cfg_coe [6];
  logic [7:0] cfg_gth, cfg_gtl;
  logic [DW-1:0] s_data;
  logic s_valid, s_last, m_ready;
  logic o_s_ready, o_m_valid, o_m_last, o_m_sof, o_busy, o_frame_done, o_frame_abort;
  logic o_line_err;
  logic [DW-1:0] o_m_data;
  logic [7:0] o_coe_00, o_coe_01, o_coe_02, o_coe_11, o_coe_12, o_coe_22, o_gth, o_gtl;

  stream_frame_ctrl #(.DW(DW), .LINE_W(LW), .FRAME_H(FH)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cont(cont), .i_abort(abort),
    .i_cfg_wr(cfg_wr),
    .i_cfg_coe_00(cfg_coe[0]), .i_cfg_coe_01(cfg_coe[1]), .i_cfg_coe_02(cfg_coe[2]),
    .i_cfg_coe_11(cfg_coe[3]), .i_cfg_coe_12(cfg_coe[4]), .i_cfg_coe_22(cfg_coe[5]),
    .i_cfg_gth(cfg_gth), .i_cfg_gtl(cfg_gtl),
    .i_s_data(s_data), .i_s_valid(s_valid), .i_s_last(s_last), .o_s_ready(o_s_ready),
    .o_m_data(o_m_data), .o_m_valid(o_m_valid), .o_m_last(o_m_last), .o_m_sof(o_m_sof),
    .i_m_ready(m_ready),
    .o_coe_00(o_coe_00), .o_coe_01(o_coe_01), .o_coe_02(o_coe_02),
    .o_coe_11(o_coe_11), .o_coe_12(o_coe_12), .o_coe_22(o_coe_22),
    .o_gth(o_gth), .o_gtl(o_gtl), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_frame_abort(o_frame_abort), .o_line_err(o_line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ph: 0 idle, 1 config-load cycle, 2 streaming, 3 frame complete
  int         ph;
  int         k;            // pixels accepted so far in this frame
  logic [7:0] pend [8];     // 6 coefficients, gth, gtl
  logic [7:0] act  [8];
  logic       m_fabort, m_lerr;

  initial begin
    logic ab, load;
    ph = 0; k = 0; m_fabort = 0; m_lerr = 0;
    for (int i = 0; i < 6; i++) begin pend[i] = 8'h04; act[i] = 8'h04; end
    pend[6] = 8'd5; act[6] = 8'd5; pend[7] = 8'd1; act[7] = 8'd1;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ph = 0; k = 0; m_fabort = 0; m_lerr = 0;
        for (int i = 0; i < 6; i++) begin pend[i] = 8'h04; act[i] = 8'h04; end
        pend[6] = 8'd5; act[6] = 8'd5; pend[7] = 8'd1; act[7] = 8'd1;
      end else begin
        ab = abort && (ph != 0);
        load = 1'b0;
        m_fabort = ab;
        if (ab) begin
          ph = 0; k = 0;
        end else begin
          case (ph)
            0: if (start) begin ph = 1; load = 1'b1; m_lerr = 1'b0; end
            1: begin ph = 2; k = 0; end
            2: if (s_valid && m_ready) begin
`ifdef LAST_CHECK_EN
                 if (s_last != ((k % LW) == LW - 1)) m_lerr = 1'b1;
`endif
                 k++;
                 if (k == NPIX) begin k = 0; ph = 3; end
               end
            default: if (cont) begin ph = 1; load = 1'b1; end else ph = 0;
          endcase
        end
        if (load) begin
          for (int i = 0; i < 7; i++) act[i] = pend[i];
          act[7] = (pend[7] > pend[6]) ? pend[6] : pend[7];
        end
        if (cfg_wr) begin
          for (int i = 0; i < 6; i++) pend[i] = cfg_coe[i];
          pend[6] = cfg_gth; pend[7] = cfg_gtl;
        end
      end
    end
  end

  // ---------------- per-cycle compare + transfer monitor ----------------
  int xfers = 0, lasts = 0, sofs = 0, dones = 0, sof_at = -1;

  always @(negedge clk) begin
    logic run;
    logic [127:0] got, exp;
    run = (ph == 2);
    exp = {run & m_ready, run & s_valid, run && ((k % LW) == LW - 1), run && (k == 0),
           ph != 0, (ph == 3) && !abort, m_fabort, m_lerr, s_data,
           act[0], act[1], act[2], act[3], act[4], act[5], act[6], act[7]};
    got = {o_s_ready, o_m_valid, o_m_last, o_m_sof, o_busy, o_frame_done, o_frame_abort,
           o_line_err, o_m_data, o_coe_00, o_coe_01, o_coe_02, o_coe_11, o_coe_12, o_coe_22,
           o_gth, o_gtl};
    chk("cycle_outputs", got, exp);
    if (s_valid && o_s_ready) begin
      if (o_m_last) lasts++;
      if (o_m_sof) begin sofs++; sof_at = xfers; end
      xfers++;
    end
    if (o_frame_done) dones++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    s_data = DW'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit toggle, input string name);
    int n;
    n = 0;
    while (o_frame_done !== 1'b1 && n < budget) begin
      if (toggle) m_ready = ((n / 3) % 2) == 0;
      tick();
      n++;
    end
    chk(name, o_frame_done, 1'b1);
  endtask

  task automatic set_cfg(input logic [7:0] c, input logic [7:0] gh, input logic [7:0] gl);
    for (int i = 0; i < 6; i++) cfg_coe[i] = c + 8'(i);
    cfg_gth = gh;
    cfg_gtl = gl;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int base;

  initial begin
    rst = 1; start = 0; cont = 0; abort = 0; cfg_wr = 0; s_valid = 0; s_last = 0;
    m_ready = 0; s_data = '0;
    set_cfg(8'h04, 8'd5, 8'd1);
    tick(); tick();
    // reset values
    chk("reset_gth", o_gth, 8'd5);
    chk("reset_gtl", o_gtl, 8'd1);
    chk("reset_coe22", o_coe_22, 8'h04);
    chk("reset_busy", o_busy, 1'b0);
    rst = 0;
    tick();

    // 1) full frame, continuous flow
    m_ready = 1; s_valid = 1;
    base = xfers;
    pulse_start();
    wait_done(200, 1'b0, "t1_done_timeout");
    tick();
    chk("t1_xfers", xfers - base, NPIX);
    chk("t1_lasts", lasts, FH);
    chk("t1_sofs", sofs, 1);
    chk("t1_sof_at_first", sof_at, base);
    chk("t1_dones", dones, 1);
    chk("t1_busy_after", o_busy, 1'b0);

    // 2) cfg_wr mid-frame only applies at next LOAD (chained by cont)
    pulse_start();
    repeat (6) tick();
    set_cfg(8'h04, 8'd9, 8'd3);
    cfg_wr = 1; tick(); cfg_wr = 0;
    chk("t2_gth_hold", o_gth, 8'd5);
    chk("t2_gtl_hold", o_gtl, 8'd1);
    cont = 1;
    wait_done(200, 1'b0, "t2_done_timeout");
    tick();
    chk("t2_gth_load", o_gth, 8'd9);
    chk("t2_gtl_load", o_gtl, 8'd3);
    cont = 0;
    wait_done(200, 1'b0, "t2b_done_timeout");
    tick();

    // 3) gtl above gth is clamped
    set_cfg(8'h11, 8'd2, 8'd7);
    cfg_wr = 1; tick(); cfg_wr = 0;
    pulse_start();
    chk("t3_gth", o_gth, 8'd2);
    chk("t3_gtl_clamp", o_gtl, 8'd2);
    chk("t3_coe00", o_coe_00, 8'h11);
    chk("t3_coe22", o_coe_22, 8'h16);
    wait_done(200, 1'b0, "t3_done_timeout");
    tick();

    // start together with cfg_wr: frame uses the old pending value
    set_cfg(8'h20, 8'd20, 8'd10);
    cfg_wr = 1; start = 1; tick(); cfg_wr = 0; start = 0;
    chk("t3b_gth_old", o_gth, 8'd2);
    wait_done(200, 1'b0, "t3b_done_timeout");
    tick();
    pulse_start();
    chk("t3c_gth_new", o_gth, 8'd20);
    chk("t3c_gtl_new", o_gtl, 8'd10);
    wait_done(200, 1'b0, "t3c_done_timeout");
    tick();

    // 4) m_ready toggling: no drop or duplicate
    base = xfers;
    pulse_start();
    wait_done(400, 1'b1, "t4_done_timeout");
    m_ready = 1;
    chk("t4_xfers", xfers - base, NPIX);
    tick();

    // 5) abort in line 2 (start mid-frame ignored)
    base = xfers;
    pulse_start();
    for (int n = 0; n < 100 && (xfers - base) < 2 * LW + 3; n++) begin
      if (n == 5) start = 1; else start = 0;
      tick();
    end
    start = 0;
    abort = 1; tick(); abort = 0;
    chk("t5_abort_pulse", o_frame_abort, 1'b1);
    chk("t5_sready_low", o_s_ready, 1'b0);
    chk("t5_busy_low", o_busy, 1'b0);
    tick();
    chk("t5_abort_once", o_frame_abort, 1'b0);
    base = xfers;
    pulse_start();
    wait_done(200, 1'b0, "t5_done_timeout");
    chk("t5_sof_restart", sof_at, base);
    tick();

    // reset mid-frame drops pending config
    set_cfg(8'h30, 8'd40, 8'd4);
    cfg_wr = 1; tick(); cfg_wr = 0;
    pulse_start();
    repeat (4) tick();
    rst = 1; tick(); rst = 0;
    chk("rst_mid_gth", o_gth, 8'd5);
    chk("rst_mid_busy", o_busy, 1'b0);
    tick();
    pulse_start();
    chk("rst_mid_pending_lost", o_gth, 8'd5);
    wait_done(200, 1'b0, "rst_done_timeout");
    tick();

    // 6) s_last on pixel LW-2
    base = xfers;
    pulse_start();
    for (int n = 0; n < 100 && (xfers - base) < LW - 2; n++) tick();
    s_last = 1; tick(); s_last = 0;
    repeat (3) tick();
`ifdef LAST_CHECK_EN
    chk("t6_line_err_set", o_line_err, 1'b1);
`else
    chk("t6_line_err_tied", o_line_err, 1'b0);
`endif
    wait_done(200, 1'b0, "t6_done_timeout");
    tick();
`ifdef LAST_CHECK_EN
    chk("t6_line_err_sticky", o_line_err, 1'b1);
`endif
    pulse_start();
    chk("t6_line_err_cleared", o_line_err, 1'b0);
    wait_done(200, 1'b0, "t6b_done_timeout");
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
